// File: rtl/mmu_tag_cam_pkg.sv
// Shared configuration, payload types and tag extraction for the MMU tag CAM.
package mmu_tag_pkg;

    localparam int unsigned ENTRIES = 8;
    localparam int unsigned VA_W    = 32;
    localparam int unsigned TAG_LSB = 20;
    localparam int unsigned DATA_W  = 24;
    localparam int unsigned IDX_W   = $clog2(ENTRIES);
    localparam int unsigned TAG_W   = VA_W - TAG_LSB;
    localparam int unsigned RD_W    = 1 + TAG_W + DATA_W;

    typedef logic [VA_W-1:0]   va_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef struct packed {
        logic  valid;
        tag_t  tag;
        data_t data;
    } rd_result_t;

    function automatic tag_t tag_of(input va_t va);
        return va[VA_W-1:TAG_LSB];
    endfunction

endpackage

// File: rtl/mmu_tag_cam_if.sv
// Fill / flush / lookup / debug-read bundle between the MMU walker, address path and tag CAM.
interface mmu_tag_cam_if;
    import mmu_tag_pkg::*;

    logic       WR_MRAM;
    va_t        WR_VA;
    data_t      WR_DATA;
    logic       FLUSH_ALL;
    logic       FLUSH_ONE;
    va_t        FLUSH_VA;
    logic       LU_REQ;
    va_t        LU_VA;
    logic       LU_VLD;
    logic       LU_HIT;
    idx_t       LU_IDX;
    data_t      LU_DATA;
    logic       MULTI_HIT;
    idx_t       RD_IDX;
    rd_result_t RD_RESULT;
    logic       FULL;

    modport master (
        output WR_MRAM, WR_VA, WR_DATA, FLUSH_ALL, FLUSH_ONE, FLUSH_VA,
               LU_REQ, LU_VA, RD_IDX,
        input  LU_VLD, LU_HIT, LU_IDX, LU_DATA, MULTI_HIT, RD_RESULT, FULL
    );

    modport slave (
        input  WR_MRAM, WR_VA, WR_DATA, FLUSH_ALL, FLUSH_ONE, FLUSH_VA,
               LU_REQ, LU_VA, RD_IDX,
        output LU_VLD, LU_HIT, LU_IDX, LU_DATA, MULTI_HIT, RD_RESULT, FULL
    );

endinterface

// File: rtl/mmu_tag_cam_match.sv
// Combinational associative compare of one probe tag against all valid entries.
import mmu_tag_pkg::*;

module mmu_tag_match (
    input  tag_t               tag_i [ENTRIES],
    input  logic [ENTRIES-1:0] valid_i,
    input  tag_t               probe_i,
    output logic [ENTRIES-1:0] match_c_o,
    output idx_t               first_c_o,
    output logic               any_c_o,
    output logic               multi_c_o
);

    always_comb begin
        match_c_o = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match_c_o[i] = valid_i[i] && (tag_i[i] == probe_i);
        end
    end

    // Lowest matching index wins.
    always_comb begin
        first_c_o = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match_c_o[i]) first_c_o = IDX_W'(i);
        end
    end

    assign any_c_o   = |match_c_o;
    assign multi_c_o = |(match_c_o & (match_c_o - 1'b1));

endmodule

// File: rtl/mmu_tag_cam.sv
// Fully associative MMU tag store: dedup/free/round-robin fill, single or full flush, 1-cycle lookup.
import mmu_tag_pkg::*;

module mmu_tag_cam (
    input logic         BCLK,
    input logic         BRESET,
    mmu_tag_cam_if.slave bus
);

    tag_t               tag_q  [ENTRIES];
    data_t              data_q [ENTRIES];
    logic [ENTRIES-1:0] valid_q, valid_d, valid_f1;
    idx_t               rp_q, rp_d;

    logic               wr_en;
    idx_t               wr_idx, free_idx;
    logic               free_any;

    logic               lu_vld_q, lu_hit_q, multi_q, full_q;
    idx_t               lu_idx_q;
    data_t              lu_data_q;
    rd_result_t         rd_q;

    logic [ENTRIES-1:0] lu_match, fl_match, wr_match;
    idx_t               lu_first, fl_first, wr_first;
    logic               lu_any, fl_any, wr_any;
    logic               lu_multi, fl_multi, wr_multi;

    mmu_tag_match u_lu_match (
        .tag_i     (tag_q),
        .valid_i   (valid_q),
        .probe_i   (tag_of(bus.LU_VA)),
        .match_c_o (lu_match),
        .first_c_o (lu_first),
        .any_c_o   (lu_any),
        .multi_c_o (lu_multi)
    );

    mmu_tag_match u_fl_match (
        .tag_i     (tag_q),
        .valid_i   (valid_q),
        .probe_i   (tag_of(bus.FLUSH_VA)),
        .match_c_o (fl_match),
        .first_c_o (fl_first),
        .any_c_o   (fl_any),
        .multi_c_o (fl_multi)
    );

    // Fill dedup sees the valid vector after a same-cycle single flush.
    mmu_tag_match u_wr_match (
        .tag_i     (tag_q),
        .valid_i   (valid_f1),
        .probe_i   (tag_of(bus.WR_VA)),
        .match_c_o (wr_match),
        .first_c_o (wr_first),
        .any_c_o   (wr_any),
        .multi_c_o (wr_multi)
    );

    logic unused_match;
    assign unused_match = ^{lu_match, fl_first, fl_any, fl_multi, wr_match, wr_multi};

    always_comb begin
        valid_f1 = valid_q & ~(bus.FLUSH_ONE ? fl_match : '0);
        free_any = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_f1[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Allocation: existing tag, then lowest free slot, then round-robin victim.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = rp_q;
        rp_d    = rp_q;
        valid_d = valid_f1;
        if (bus.FLUSH_ALL) begin
            valid_d = '0;
            rp_d    = '0;
        end else if (bus.WR_MRAM) begin
            wr_en = 1'b1;
            if (wr_any) begin
                wr_idx = wr_first;
            end else if (free_any) begin
                wr_idx = free_idx;
            end else begin
                wr_idx = rp_q;
                rp_d   = rp_q + 1'b1;
            end
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge BCLK or negedge BRESET) begin
        if (!BRESET) begin
            valid_q <= '0;
            rp_q    <= '0;
            full_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rp_q    <= rp_d;
            full_q  <= &valid_d;
        end
    end

    // Tag/data payload is not reset; valid qualifies it.
    always_ff @(posedge BCLK) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= tag_of(bus.WR_VA);
            data_q[wr_idx] <= bus.WR_DATA;
        end
    end

    always_ff @(posedge BCLK or negedge BRESET) begin
        if (!BRESET) begin
            lu_vld_q  <= 1'b0;
            lu_hit_q  <= 1'b0;
            lu_idx_q  <= '0;
            lu_data_q <= '0;
            multi_q   <= 1'b0;
            rd_q      <= '0;
        end else begin
            lu_vld_q <= bus.LU_REQ;
            if (bus.LU_REQ) begin
                lu_hit_q  <= lu_any;
                lu_idx_q  <= lu_any ? lu_first : '0;
                lu_data_q <= lu_any ? data_q[lu_first] : '0;
                multi_q   <= lu_multi;
            end
            rd_q.valid <= valid_q[bus.RD_IDX];
            rd_q.tag   <= tag_q[bus.RD_IDX];
            rd_q.data  <= data_q[bus.RD_IDX];
        end
    end

    assign bus.LU_VLD    = lu_vld_q;
    assign bus.LU_HIT    = lu_hit_q;
    assign bus.LU_IDX    = lu_idx_q;
    assign bus.LU_DATA   = lu_data_q;
    assign bus.MULTI_HIT = multi_q;
    assign bus.RD_RESULT = rd_q;
    assign bus.FULL      = full_q;

endmodule

// File: tb/tb_mmu_tag_cam.sv
// Randomised and directed bench for mmu_tag_cam against an array-based reference model.
import mmu_tag_pkg::*;

module tb_mmu_tag_cam;

    logic clk;
    logic rst_n;

    mmu_tag_cam_if bus ();

    mmu_tag_cam dut (
        .BCLK   (clk),
        .BRESET (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model state
    bit    m_valid   [ENTRIES];
    bit    m_written [ENTRIES];
    tag_t  m_tag     [ENTRIES];
    data_t m_data    [ENTRIES];
    int    m_rp;

    // Expected registered outputs
    bit    e_vld, e_hit, e_multi;
    int    e_idx;
    data_t e_data;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic va_t mk_va(input tag_t t);
        logic [TAG_LSB-1:0] low;
        low = TAG_LSB'($urandom);
        return {t, low};
    endfunction

    task automatic idle();
        bus.WR_MRAM   = 1'b0;
        bus.WR_VA     = '0;
        bus.WR_DATA   = '0;
        bus.FLUSH_ALL = 1'b0;
        bus.FLUSH_ONE = 1'b0;
        bus.FLUSH_VA  = '0;
        bus.LU_REQ    = 1'b0;
        bus.LU_VA     = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_rp    = 0;
        e_vld   = 1'b0;
        e_hit   = 1'b0;
        e_multi = 1'b0;
        e_idx   = 0;
        e_data  = '0;
    endtask

    task automatic model_update();
        tag_t ft, wt;
        int   slot;
        if (bus.FLUSH_ALL) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
            m_rp = 0;
        end else begin
            if (bus.FLUSH_ONE) begin
                ft = tag_of(bus.FLUSH_VA);
                for (int i = 0; i < ENTRIES; i++)
                    if (m_valid[i] && m_tag[i] == ft) m_valid[i] = 1'b0;
            end
            if (bus.WR_MRAM) begin
                wt   = tag_of(bus.WR_VA);
                slot = -1;
                for (int i = 0; i < ENTRIES; i++)
                    if (slot < 0 && m_valid[i] && m_tag[i] == wt) slot = i;
                for (int i = 0; i < ENTRIES; i++)
                    if (slot < 0 && !m_valid[i]) slot = i;
                if (slot < 0) begin
                    slot = m_rp;
                    m_rp = (m_rp + 1) % ENTRIES;
                end
                m_valid[slot]   = 1'b1;
                m_written[slot] = 1'b1;
                m_tag[slot]     = wt;
                m_data[slot]    = bus.WR_DATA;
            end
        end
    endtask

    // One clock: derive expectations from pre-edge model, advance, then compare.
    task automatic cycle();
        tag_t  lt;
        int    cnt, fi, ri;
        bit    rv, rk, full;
        tag_t  rt;
        data_t rdd;
        if (bus.LU_REQ) begin
            lt  = tag_of(bus.LU_VA);
            cnt = 0;
            fi  = -1;
            for (int i = 0; i < ENTRIES; i++) begin
                if (m_valid[i] && m_tag[i] == lt) begin
                    cnt++;
                    if (fi < 0) fi = i;
                end
            end
            e_hit   = (cnt > 0);
            e_multi = (cnt > 1);
            e_idx   = (fi < 0) ? 0 : fi;
            e_data  = (fi < 0) ? '0 : m_data[fi];
        end
        e_vld = bus.LU_REQ;
        ri  = int'(bus.RD_IDX);
        rv  = m_valid[ri];
        rk  = m_written[ri];
        rt  = m_tag[ri];
        rdd = m_data[ri];
        @(posedge clk);
        model_update();
        #1;
        full = 1'b1;
        for (int i = 0; i < ENTRIES; i++) full &= m_valid[i];
        chk("lu_vld", 64'(bus.LU_VLD), 64'(e_vld));
        chk("lu_hit", 64'(bus.LU_HIT), 64'(e_hit));
        chk("lu_idx", 64'(bus.LU_IDX), 64'(e_idx));
        chk("lu_data", 64'(bus.LU_DATA), 64'(e_data));
        chk("multi_hit", 64'(bus.MULTI_HIT), 64'(e_multi));
        chk("full", 64'(bus.FULL), 64'(full));
        chk("rd_valid", 64'(bus.RD_RESULT.valid), 64'(rv));
        if (rk) begin
            chk("rd_tag", 64'(bus.RD_RESULT.tag), 64'(rt));
            chk("rd_data", 64'(bus.RD_RESULT.data), 64'(rdd));
        end
    endtask

    task automatic fill(input tag_t t, input data_t d);
        bus.WR_MRAM = 1'b1;
        bus.WR_VA   = mk_va(t);
        bus.WR_DATA = d;
        cycle();
        idle();
    endtask

    task automatic lookup(input tag_t t);
        bus.LU_REQ = 1'b1;
        bus.LU_VA  = mk_va(t);
        cycle();
        idle();
    endtask

    task automatic rd_peek(input int i);
        bus.RD_IDX = IDX_W'(i);
        cycle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < ENTRIES; i++) m_written[i] = 1'b0;
        idle();
        bus.RD_IDX = '0;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lu_vld", 64'(bus.LU_VLD), 64'd0);
        chk("rst_lu_hit", 64'(bus.LU_HIT), 64'd0);
        chk("rst_lu_idx", 64'(bus.LU_IDX), 64'd0);
        chk("rst_lu_data", 64'(bus.LU_DATA), 64'd0);
        chk("rst_multi", 64'(bus.MULTI_HIT), 64'd0);
        chk("rst_rd", 64'(bus.RD_RESULT), 64'd0);
        chk("rst_full", 64'(bus.FULL), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill all entries, then hit the middle one
        for (int n = 1; n <= 8; n++) fill(TAG_W'(n), DATA_W'(32'hA00000 + n));
        chk("d_full8", 64'(bus.FULL), 64'd1);
        lookup(TAG_W'(5));
        chk("d_lu5_vld", 64'(bus.LU_VLD), 64'd1);
        chk("d_lu5_hit", 64'(bus.LU_HIT), 64'd1);
        chk("d_lu5_idx", 64'(bus.LU_IDX), 64'd4);
        chk("d_lu5_data", 64'(bus.LU_DATA), 64'hA00005);

        // Round-robin wrap
        fill(TAG_W'(9), DATA_W'(32'hA00009));
        fill(TAG_W'(10), DATA_W'(32'hA0000A));
        rd_peek(0);
        chk("d_wrap0_tag", 64'(bus.RD_RESULT.tag), 64'h009);
        rd_peek(1);
        chk("d_wrap1_tag", 64'(bus.RD_RESULT.tag), 64'h00A);
        lookup(TAG_W'(1));
        chk("d_lu1_miss", 64'(bus.LU_HIT), 64'd0);

        // Duplicate refill overwrites in place
        fill(TAG_W'(3), DATA_W'(32'h555555));
        lookup(TAG_W'(3));
        chk("d_dup_idx", 64'(bus.LU_IDX), 64'd2);
        chk("d_dup_data", 64'(bus.LU_DATA), 64'h555555);
        chk("d_dup_multi", 64'(bus.MULTI_HIT), 64'd0);

        // Single flush frees a slot that the next fill takes
        bus.FLUSH_ONE = 1'b1;
        bus.FLUSH_VA  = mk_va(TAG_W'(4));
        cycle();
        idle();
        chk("d_f1_full", 64'(bus.FULL), 64'd0);
        fill(TAG_W'(11), DATA_W'(32'hBBBBBB));
        rd_peek(3);
        chk("d_f1_tag", 64'(bus.RD_RESULT.tag), 64'h00B);
        chk("d_f1_vld", 64'(bus.RD_RESULT.valid), 64'd1);

        // Fill and lookup of the same tag in one cycle: miss, then hit
        bus.WR_MRAM = 1'b1;
        bus.WR_VA   = mk_va(TAG_W'(12'h0AA));
        bus.WR_DATA = DATA_W'(32'h0000AA);
        bus.LU_REQ  = 1'b1;
        bus.LU_VA   = mk_va(TAG_W'(12'h0AA));
        cycle();
        idle();
        chk("d_same_miss", 64'(bus.LU_HIT), 64'd0);
        lookup(TAG_W'(12'h0AA));
        chk("d_next_hit", 64'(bus.LU_HIT), 64'd1);
        chk("d_next_idx", 64'(bus.LU_IDX), 64'd2);

        // Full flush drops a concurrent fill and rewinds the pointer
        bus.FLUSH_ALL = 1'b1;
        bus.WR_MRAM   = 1'b1;
        bus.WR_VA     = mk_va(TAG_W'(12'h0BB));
        bus.WR_DATA   = DATA_W'(32'h123456);
        cycle();
        idle();
        chk("d_fa_full", 64'(bus.FULL), 64'd0);
        lookup(TAG_W'(12'h0BB));
        chk("d_fa_miss", 64'(bus.LU_HIT), 64'd0);
        for (int n = 0; n < 9; n++) fill(TAG_W'(12'h020 + n), DATA_W'(n));
        rd_peek(0);
        chk("d_fa_rp0", 64'(bus.RD_RESULT.tag), 64'h028);

        // Reset in the middle of a lookup
        bus.LU_REQ = 1'b1;
        bus.LU_VA  = mk_va(TAG_W'(12'h021));
        #2 rst_n = 1'b0;
        #1;
        chk("d_mid_rst_vld", 64'(bus.LU_VLD), 64'd0);
        idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("d_post_rst_vld", 64'(bus.LU_VLD), 64'd0);
        for (int i = 0; i < ENTRIES; i++) begin
            rd_peek(i);
            chk("d_post_rst_rdv", 64'(bus.RD_RESULT.valid), 64'd0);
        end

        // Randomised traffic over a small tag pool
        for (int c = 0; c < 800; c++) begin
            bus.FLUSH_ALL = ($urandom_range(0, 99) < 3);
            bus.FLUSH_ONE = ($urandom_range(0, 99) < 12);
            bus.FLUSH_VA  = mk_va(TAG_W'($urandom_range(1, 12)));
            bus.WR_MRAM   = ($urandom_range(0, 99) < 45);
            bus.WR_VA     = mk_va(TAG_W'($urandom_range(1, 12)));
            bus.WR_DATA   = DATA_W'($urandom);
            bus.LU_REQ    = ($urandom_range(0, 99) < 60);
            bus.LU_VA     = mk_va(TAG_W'($urandom_range(1, 12)));
            bus.RD_IDX    = IDX_W'($urandom_range(0, ENTRIES - 1));
            cycle();
        end
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmu_tag_cam.md
# mmu_tag_cam

Parametrised, fully associative MMU translation tag store with valid bits, round-robin replacement, hit lookup, and single-tag or full flush. It holds up to ENTRIES tags taken from the virtual address upper bits, each paired with a DATA_W translation payload. It sits between the MMU table-walk logic, which fills entries, and the address path, which issues lookups. It generalises the earlier 4-entry, index-addressed tag RAM: it is single-clock, has configurable depth and width, and adds associative match, valid tracking and replacement.

## Interface
- ENTRIES, 8: number of entries; a power of two, at least 2. IDX_W = $clog2(ENTRIES).
- VA_W, 32: virtual address width.
- TAG_LSB, 20: the tag is VA[VA_W-1:TAG_LSB]. TAG_W = VA_W - TAG_LSB.
- DATA_W, 24: payload width.

- BCLK  in  1  clock; everything updates on the rising edge.
- BRESET  in  1  asynchronous, active-low reset.
- WR_MRAM  in  1  fill request.
- WR_VA  in  VA_W  fill virtual address; only the tag bits are used.
- WR_DATA  in  DATA_W  fill payload.
- FLUSH_ALL  in  1  invalidate every entry.
- FLUSH_ONE  in  1  invalidate the entry whose tag matches FLUSH_VA.
- FLUSH_VA  in  VA_W  address for FLUSH_ONE.
- LU_REQ  in  1  lookup request.
- LU_VA  in  VA_W  lookup address.
- LU_VLD  out  1  lookup result valid.
- LU_HIT  out  1  a valid entry matched.
- LU_IDX  out  IDX_W  index of the matching entry.
- LU_DATA  out  DATA_W  payload of the matching entry.
- MULTI_HIT  out  1  more than one valid entry matched; error flag.
- RD_IDX  in  IDX_W  debug read index.
- RD_RESULT  out  1+TAG_W+DATA_W  {valid, tag, data} at RD_IDX, registered.
- FULL  out  1  all entries valid.

## Operation
- **Storage:** tag[ENTRIES], data[ENTRIES], valid[ENTRIES].
  - Reset clears only valid and the replacement pointer (rp).
  - Tag and data contents are undefined after reset.
- **Fill (WR_MRAM=1):**
  - If a valid entry already holds the same tag, overwrite that entry; lowest index wins if several match. rp is unchanged.
  - Otherwise, if any entry is invalid, write the lowest-index invalid entry. rp is unchanged.
  - Otherwise write entry rp, then rp <= rp+1, wrapping ENTRIES-1 -> 0.
  - The written entry becomes valid=1.
- **FLUSH_ONE:** clears valid on every valid entry whose tag matches FLUSH_VA. A miss has no effect.
- **FLUSH_ALL:** clears all valid bits and sets rp <= 0.
- **Priority within one cycle:**
  - FLUSH_ALL beats everything; a concurrent fill or FLUSH_ONE is dropped.
  - FLUSH_ONE is applied before the fill. A fill of the same tag therefore lands in a freshly invalid slot and ends up valid.
  - Allocation for that fill uses the valid vector after the FLUSH_ONE clear.
- **Lookup:** compares the LU_VA tag against every valid entry using pre-edge state.
  - A same-cycle fill or flush is not visible to that lookup.
  - On multiple matches, LU_IDX and LU_DATA come from the lowest index, and MULTI_HIT=1.
  - On a miss: LU_HIT=0, LU_IDX=0, LU_DATA=0.
- **Back-to-back lookups** are allowed every cycle.
- **FULL** is registered, reflects the state after the edge, and is combinationally derived from valid.

## Timing
- **Lookup latency:** 1 cycle. LU_REQ in cycle n gives LU_VLD=1 with results in cycle n+1. LU_VLD=0 and the other LU_* outputs hold their last value when there is no request.
- **Fill latency:** a fill in cycle n is visible to a lookup issued in cycle n+1.
- **Flush latency:** a flush in cycle n takes effect for a lookup issued in cycle n+1.
- **RD_RESULT:** registered, 1-cycle latency from RD_IDX. It shows state after the previous edge.
- **Reset values:** LU_VLD=0, LU_HIT=0, LU_IDX=0, LU_DATA=0, MULTI_HIT=0, RD_RESULT=0, FULL=0, rp=0.
- **Reset mid-operation:** an in-flight lookup is discarded, and LU_VLD is 0 on the first edge after release.
- **No backpressure:** there are no ready signals; the block accepts a fill, a flush and a lookup every cycle.

## Structure
- **Package mmu_tag_pkg:** localparams for IDX_W and TAG_W derivation, plus a function tag_of(va) that extracts the tag.
- **Sub-module mmu_tag_match:**
  - Inputs: the tag vector, the valid vector and one probe tag.
  - Outputs: a match vector, first-match index, any-match and multi-match.
  - Purely combinational; instantiated three times, for lookup, fill de-duplication and FLUSH_ONE.
- **Top level:** storage, the rp counter, allocation priority encoder and output registers.

## Test plan
- **Reset then fill:** reset, then fill 8 distinct tags 0x001..0x008 with data 0xA0000n. FULL=1 after the 8th fill. Lookup of tag 0x005 -> LU_HIT=1, LU_IDX=4, LU_DATA=0xA00005, one cycle after LU_REQ.
- **Replacement wrap:** fill a 9th tag 0x009 -> it replaces index 0 and rp=1. A 10th fill replaces index 1. Lookup of 0x001 -> miss.
- **Duplicate fill:** refill existing tag 0x003 with 0x555555 -> the same index is overwritten, rp is unchanged, and MULTI_HIT stays 0.
- **FLUSH_ONE:** flush tag 0x004 -> FULL=0. The next fill takes index 3 and rp is unchanged.
- **Same-cycle fill and lookup:** fill tag 0x0AA while looking up 0x0AA in the same cycle -> miss. A lookup in the next cycle -> hit.
- **Flush priority:** FLUSH_ALL together with a fill -> all valid bits cleared, the fill dropped, rp=0. Asserting BRESET low mid-lookup -> LU_VLD=0 and all entries read valid=0 on RD_RESULT.
